// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg: shared state encoding and width helper for the debouncer
package sync_debounce_pkg;
  typedef enum logic {ST_STABLE = 1'b0, ST_CHECK = 1'b1} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_debounce_sync_chain.sv
// sync_chain: multi-flop synchroniser for an asynchronous single-bit input
module sync_chain #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] sr_q;
  always_ff @(posedge clk) sr_q <= !rst ? {DEPTH{RST_VAL}} : {sr_q[DEPTH-2:0], d_i};
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: synchronise a raw input and accept a new level only after
// STABLE_CYCLES consecutive enabled samples, with rise/fall pulses
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic INIT_LEVEL    = 1'b0,
  localparam int  CNT_W         = clog2(STABLE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic sample_en,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic sync_out;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dout_q, dout_d, rise_q, rise_d, fall_q, fall_d;
  sync_chain #(.DEPTH(SYNC_STAGES), .RST_VAL(INIT_LEVEL)) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(din),
    .q_o(sync_out)
  );
  // A mismatch first moves to CHECK; counting starts on the following samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_out == dout_q) begin
      state_d = ST_STABLE;
      cnt_d   = '0;
    end else if (state_q == ST_STABLE) begin
      state_d = ST_CHECK;
    end else if (sample_en) begin
      if (cnt_q == LAST) begin
        dout_d  = sync_out;
        rise_d  = sync_out;
        fall_d  = !sync_out;
        cnt_d   = '0;
        state_d = ST_STABLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      dout_q  <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = state_q == ST_CHECK;
endmodule
